// File: rtl/nibble_divider_seq.sv
// rtl/nibble_divider_seq.sv - nibble-loaded 8-by-4 unsigned restoring divider
// Loads dividend high/low and divisor over a 4-bit bus, then produces one quotient bit per cycle.
module nibble_divider_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] nib_in,
  input  logic       nib_valid,
  output logic       ready,
  output logic       busy,
  output logic [7:0] q_out,
  output logic [3:0] r_out,
  output logic       done,
  output logic       div_zero
);

  typedef enum logic [2:0] {
    LOAD_HI  = 3'd0,
    LOAD_LO  = 3'd1,
    LOAD_DIV = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] dvd_q;
  logic [3:0] prem_q;
  logic [6:0] quo_q;
  logic [3:0] dsr_q;
  logic [2:0] cnt_q;
  logic [7:0] q_q;
  logic [3:0] r_q;
  logic       done_q;
  logic       dz_q;

  logic       accept;
  logic [4:0] trial;
  logic       qbit;
  logic [3:0] prem_d;

  assign accept = nib_valid && ready;

  // The partial remainder never exceeds the divisor after restoring, so its top bit
  // is always zero and only four bits are held; the low-bit subtraction is exact.
  assign trial  = {prem_q, dvd_q[7]};
  assign qbit   = (trial >= {1'b0, dsr_q});
  assign prem_d = qbit ? (trial[3:0] - dsr_q) : trial[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_HI;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_HI:  if (accept) state_d = LOAD_LO;
      LOAD_LO:  if (accept) state_d = LOAD_DIV;
      LOAD_DIV: if (accept) state_d = (nib_in == 4'h0) ? DONE : RUN;
      RUN:      if (cnt_q == 3'd7) state_d = DONE;
      DONE:     state_d = LOAD_HI;
      default:  state_d = LOAD_HI;
    endcase
  end

  always_comb begin
    ready = (state_q == LOAD_HI) || (state_q == LOAD_LO) || (state_q == LOAD_DIV);
    busy  = (state_q == RUN) || (state_q == DONE);
  end

  // The eighth quotient bit goes straight to q_out, so seven bits are kept in quo_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q  <= 8'h00;
      prem_q <= 4'h0;
      quo_q  <= 7'h00;
      dsr_q  <= 4'h0;
      cnt_q  <= 3'd0;
      q_q    <= 8'h00;
      r_q    <= 4'h0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        LOAD_HI: if (accept) dvd_q[7:4] <= nib_in;
        LOAD_LO: if (accept) dvd_q[3:0] <= nib_in;
        LOAD_DIV: begin
          if (accept) begin
            dsr_q  <= nib_in;
            prem_q <= 4'h0;
            quo_q  <= 7'h00;
            cnt_q  <= 3'd0;
            if (nib_in == 4'h0) begin
              q_q    <= 8'hFF;
              r_q    <= 4'hF;
              dz_q   <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd_q  <= {dvd_q[6:0], 1'b0};
          prem_q <= prem_d;
          quo_q  <= {quo_q[5:0], qbit};
          cnt_q  <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            q_q    <= {quo_q, qbit};
            r_q    <= prem_d;
            dz_q   <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign q_out    = q_q;
  assign r_out    = r_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_nibble_divider_seq.sv
// tb/tb_nibble_divider_seq.sv - directed and reference-model checks for nibble_divider_seq
module tb_nibble_divider_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] nib_in;
  logic       nib_valid;
  logic       ready;
  logic       busy;
  logic [7:0] q_out;
  logic [3:0] r_out;
  logic       done;
  logic       div_zero;

  int checks = 0;
  int errors = 0;

  nibble_divider_seq dut (
    .clk      (clk),
    .rst      (rst),
    .nib_in   (nib_in),
    .nib_valid(nib_valid),
    .ready    (ready),
    .busy     (busy),
    .q_out    (q_out),
    .r_out    (r_out),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_nib(input logic [3:0] n, input int gap);
    repeat (gap) begin
      @(negedge clk);
      nib_valid = 1'b0;
      nib_in    = 4'h0;
    end
    @(negedge clk);
    nib_valid = 1'b1;
    nib_in    = n;
    @(posedge clk);
  endtask

  task automatic run_op(input string tag, input logic [7:0] dvd, input logic [3:0] dsr,
                        input logic [7:0] exp_q, input logic [3:0] exp_r, input logic exp_z,
                        input int gap, input bit toggle);
    int lat;
    int rlo;
    lat = 0;
    rlo = 0;
    send_nib(dvd[7:4], gap);
    send_nib(dvd[3:0], gap);
    send_nib(dsr, gap);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      nib_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
      nib_in    = 4'($urandom_range(0, 15));
      if (!ready) rlo++;
      if (i == 1) chk({tag, " busy"}, busy, 1'b1);
      if (done) begin
        lat = i;
        break;
      end
    end
    nib_valid = 1'b0;
    chk({tag, " latency"}, lat, exp_z ? 1 : 9);
    chk({tag, " ready_low"}, rlo, exp_z ? 1 : 9);
    chk({tag, " q_out"}, q_out, exp_q);
    chk({tag, " r_out"}, r_out, exp_r);
    chk({tag, " div_zero"}, div_zero, exp_z);
    @(negedge clk);
    chk({tag, " done_once"}, done, 1'b0);
    chk({tag, " ready_back"}, ready, 1'b1);
  endtask

  initial begin
    logic [7:0] rd;
    logic [3:0] rs;
    int         dcount;
    rst       = 1'b1;
    nib_valid = 1'b1;
    nib_in    = 4'h9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    nib_valid = 1'b0;
    chk("rst ready", ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst div_zero", div_zero, 1'b0);
    chk("rst q_out", q_out, 8'h00);
    chk("rst r_out", r_out, 4'h0);

    run_op("c3/5", 8'hC3, 4'h5, 8'h27, 4'h0, 1'b0, 0, 1'b0);
    run_op("64/7", 8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 0, 1'b0);
    run_op("05/9", 8'h05, 4'h9, 8'h00, 4'h5, 1'b0, 0, 1'b0);
    run_op("ff/1", 8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, 0, 1'b0);
    run_op("ff/f", 8'hFF, 4'hF, 8'h11, 4'h0, 1'b0, 0, 1'b0);
    run_op("a5/0", 8'hA5, 4'h0, 8'hFF, 4'hF, 1'b1, 0, 1'b0);
    run_op("10/4", 8'h10, 4'h4, 8'h04, 4'h0, 1'b0, 0, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op("sweep", 8'(a * b), 4'(b), 8'(a), 4'h0, 1'b0, 0, 1'b0);
      end
    end

    for (int k = 0; k < 30; k++) begin
      rd = 8'($urandom_range(0, 255));
      rs = 4'($urandom_range(1, 15));
      run_op("random", rd, rs, 8'(int'(rd) / int'(rs)), 4'(int'(rd) % int'(rs)), 1'b0,
             $urandom_range(0, 2), 1'b1);
    end

    send_nib(4'h6, 0);
    send_nib(4'h4, 0);
    send_nib(4'h7, 0);
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      nib_valid = 1'b0;
      if (done) dcount++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun ready", ready, 1'b1);
    chk("midrun q_out", q_out, 8'h00);
    chk("midrun r_out", r_out, 4'h0);
    chk("midrun busy", busy, 1'b0);
    repeat (12) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("midrun no_done", dcount, 0);

    run_op("2d/3", 8'h2D, 4'h3, 8'h0F, 4'h0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle q_out", q_out, 8'h0F);
      chk("idle r_out", r_out, 4'h0);
      chk("idle done", done, 1'b0);
      chk("idle ready", ready, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
